// File: rtl/mips_pkg.sv
// Shared constants and the next-PC selection enum for the instruction fetch stage.
package mips_pkg;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_HOLD,
    PC_REDIR,
    PC_IRQ,
    PC_EXC
  } pc_sel_t;

  // Any selection that replaces the instruction currently being fetched.
  function automatic logic is_flush(input pc_sel_t sel);
    return (sel == PC_REDIR) || (sel == PC_IRQ) || (sel == PC_EXC);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Combinational priority encoder choosing the next PC source:
// exception > unmasked interrupt > redirect > stall > sequential.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        irq_req,
  input  logic        exc_req,
  output pc_sel_t     sel,
  output logic [31:0] next_pc
);

  logic [31:0] redir_tgt;

  always_comb begin
    redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    // User mode cannot branch into the supervisor half of the address space.
    if (!pc[31]) redir_tgt[31] = 1'b0;

    sel     = PC_SEQ;
    next_pc = pc + 32'd4;
    if (exc_req) begin
      sel     = PC_EXC;
      next_pc = EXC_VEC;
    end else if (irq_req && !pc[31]) begin
      sel     = PC_IRQ;
      next_pc = IRQ_VEC;
    end else if (redirect_valid) begin
      sel     = PC_REDIR;
      next_pc = redir_tgt;
    end else if (stall) begin
      sel     = PC_HOLD;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, reads the combinational ROM and loads the IF/ID register.
// Optional fetch/bubble performance counters are built when IFETCH_PERF_EN is defined.
module instr_fetch_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        irq_req,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [31:0] epc,
  output logic        vec_taken
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  pc_sel_t     sel;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] epc_q, epc_d;
  logic        vec_taken_q, vec_taken_d;

  next_pc_sel u_next_pc_sel (
    .pc             (pc_q),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq_req        (irq_req),
    .exc_req        (exc_req),
    .sel            (sel),
    .next_pc        (next_pc)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d          = next_pc;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    epc_d         = epc_q;
    vec_taken_d   = 1'b0;
    case (sel)
      PC_SEQ: begin
        if_id_instr_d = rom_data;
        if_id_pc4_d   = pc_plus4;
      end
      PC_REDIR: begin
        if_id_instr_d = NOP_INSTR;
        if_id_pc4_d   = pc_plus4;
      end
      PC_IRQ, PC_EXC: begin
        // The flushed fetch is the one to resume at after the handler.
        if_id_instr_d = NOP_INSTR;
        if_id_pc4_d   = pc_plus4;
        epc_d         = pc_q;
        vec_taken_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VEC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= 32'd0;
      epc_q         <= 32'd0;
      vec_taken_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      epc_q         <= epc_d;
      vec_taken_q   <= vec_taken_d;
    end
  end

  assign rom_addr    = {2'b00, pc_q[31:2]};
  assign pc          = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign epc         = epc_q;
  assign vec_taken   = vec_taken_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (sel == PC_SEQ) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (sel == PC_HOLD || is_flush(sel)) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and random bench for instr_fetch_unit against a behavioural next-state model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr, rom_data;
  logic        stall, redirect_valid, irq_req, exc_req;
  logic [31:0] redirect_pc;
  logic [31:0] pc, if_id_instr, if_id_pc4, epc;
  logic        vec_taken;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  logic [31:0] rom [256];
  assign rom_data = rom[rom_addr[7:0]];

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq_req        (irq_req),
    .exc_req        (exc_req),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .epc            (epc),
    .vec_taken      (vec_taken)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  bit          m_valid = 0;
  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_vec;
  logic [31:0] m_fetch, m_bubble;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance model by the architectural rules, compare.
  task automatic step(input bit r, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit irq, input bit exc);
    logic [31:0] tgt;
    logic [31:0] word;
    reset = r; stall = st; redirect_valid = rv; redirect_pc = rpc;
    irq_req = irq; exc_req = exc;
    #1;
    if (m_valid) check("rom_addr", rom_addr, m_pc >> 2);
    word = rom[m_pc[9:2]];
    @(posedge clk);
    if (r) begin
      m_valid = 1; m_pc = RESET_VEC; m_instr = 0; m_pc4 = 0; m_epc = 0; m_vec = 0;
      m_fetch = 0; m_bubble = 0;
    end else if (exc || (irq && !m_pc[31])) begin
      m_epc = m_pc; m_vec = 1; m_instr = 0; m_pc4 = m_pc + 4;
      m_pc = exc ? EXC_VEC : IRQ_VEC; m_bubble++;
    end else if (rv) begin
      tgt = {rpc[31:2], 2'b00};
      if (!m_pc[31]) tgt = tgt & 32'h7FFF_FFFF;
      m_vec = 0; m_instr = 0; m_pc4 = m_pc + 4; m_pc = tgt; m_bubble++;
    end else if (st) begin
      m_vec = 0; m_bubble++;
    end else begin
      m_vec = 0; m_instr = word; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_fetch++;
    end
    #1;
    check("pc", pc, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc4", if_id_pc4, m_pc4);
    check("epc", epc, m_epc);
    check("vec_taken", {31'd0, vec_taken}, {31'd0, m_vec});
`ifdef IFETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("bubble_cnt", bubble_cnt, m_bubble);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h0800_0003;

    // Reset, then first fetch
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_pc", pc, 32'h8000_0000);
    check("reset_rom_addr", rom_addr, 32'h2000_0000);
    check("reset_pc4", if_id_pc4, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    check("first_instr", if_id_instr, 32'h0800_0003);
    check("first_pc4", if_id_pc4, 32'h8000_0004);
    step(0, 0, 0, 0, 0, 0);
    check("seq_pc", pc, 32'h8000_0008);

    // Stall holds, then resumes
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("stall_pc", pc, 32'h8000_0008);
    step(0, 0, 0, 0, 0, 0);
    check("resume_pc", pc, 32'h8000_000C);

    // Redirects, including user-mode supervisor-bit masking
    step(0, 0, 1, 32'h8000_0050, 0, 0);
    check("redir_pc", pc, 32'h8000_0050);
    check("redir_nop", if_id_instr, 32'h0);
    step(0, 1, 1, 32'h0000_0013, 0, 0);
    check("redir_user", pc, 32'h0000_0010);
    step(0, 0, 1, 32'h8000_0040, 0, 0);
    check("redir_masked", pc, 32'h0000_0040);

    // Interrupt masked in kernel mode, taken in user mode
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 32'h0000_0054, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check("irq_pc", pc, IRQ_VEC);
    check("irq_epc", epc, 32'h0000_0054);
    check("irq_vec", {31'd0, vec_taken}, 32'd1);
    step(0, 0, 0, 0, 1, 0);
    check("irq_kernel_ignored", pc, 32'h8000_0008);
    step(0, 0, 1, 32'h8000_0020, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check("irq_masked", pc, 32'h8000_0024);

    // Everything at once in user mode, then reset mid-stall
    step(0, 0, 1, 32'h0000_0100, 0, 0);
    step(0, 1, 1, 32'h0000_0200, 1, 1);
    check("all_events_pc", pc, EXC_VEC);
    check("all_events_epc", epc, 32'h0000_0100);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("reset_mid_stall", pc, RESET_VEC);

    // 32-bit wrap
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_pc4", if_id_pc4, 32'h0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
           $urandom, ($urandom_range(7) == 0), ($urandom_range(31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
